// File: rtl/steering_scan_ctrl.sv
// Steered-response-power scan: steps the beamformer over a h/v angle grid, integrates output
// energy per point and reports the strongest point. Define STEER_POINT_STREAM_EN for a per-point energy stream.
module steering_scan_ctrl #(
    parameter int BIT_WIDTH      = 8,
    parameter int HORI_STEPS     = 5,
    parameter int VERT_STEPS     = 5,
    parameter int ANGLE_STRIDE   = 1,
    parameter int EN_HIGH_CYCLES = 4,
    parameter int SETTLE_CYCLES  = 64,
    parameter int WINDOW_LEN     = 256,
    parameter int ACC_WIDTH      = 2*BIT_WIDTH + $clog2(WINDOW_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 sample_valid,
    input  logic [BIT_WIDTH-1:0] delay_sum_data_in,
    output logic                 steering_angle_en_async,
    output logic [7:0]           steering_angle_hori,
    output logic [7:0]           steering_angle_vert,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           best_hori,
    output logic [7:0]           best_vert,
    output logic [ACC_WIDTH-1:0] best_energy
`ifdef STEER_POINT_STREAM_EN
    ,
    output logic                 point_valid,
    output logic [7:0]           point_hori,
    output logic [7:0]           point_vert,
    output logic [ACC_WIDTH-1:0] point_energy
`endif
);

    localparam int CNT_MAX0 = (EN_HIGH_CYCLES > SETTLE_CYCLES) ? EN_HIGH_CYCLES : SETTLE_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > WINDOW_LEN) ? CNT_MAX0 : WINDOW_LEN;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int IDX_W    = 16;

    typedef enum logic [2:0] {IDLE, PULSE, SETTLE, MEASURE, COMPARE, DONE} state_t;

    state_t                   state_reg, state_next;
    logic [CNT_W-1:0]         cnt_reg;
    logic [IDX_W-1:0]         h_reg, v_reg, h_adv, v_adv;
    logic [ACC_WIDTH-1:0]     acc_reg, best_acc_reg;
    logic [7:0]               best_h_reg, best_v_reg;
    logic                     best_valid_reg;
    logic                     h_last, v_last, better;
    logic signed [2*BIT_WIDTH-1:0] sample_ext;
    logic [2*BIT_WIDTH-1:0]   sample_sq;

    function automatic logic [7:0] to_angle(input logic [IDX_W-1:0] idx);
        return 8'(32'(idx) * 32'(ANGLE_STRIDE));
    endfunction

    // Sign-extend before squaring so the low 2*BIT_WIDTH product bits are the exact square.
    assign sample_ext = {{BIT_WIDTH{delay_sum_data_in[BIT_WIDTH-1]}}, delay_sum_data_in};
    assign sample_sq  = sample_ext * sample_ext;

    assign h_last = (h_reg == IDX_W'(HORI_STEPS - 1));
    assign v_last = (v_reg == IDX_W'(VERT_STEPS - 1));
    assign h_adv  = h_last ? '0 : h_reg + IDX_W'(1);
    assign v_adv  = h_last ? v_reg + IDX_W'(1) : v_reg;
    assign better = !best_valid_reg || (acc_reg > best_acc_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next              = state_reg;
        busy                    = (state_reg != IDLE);
        done                    = (state_reg == DONE);
        steering_angle_en_async = (state_reg == PULSE);
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (start) state_next = PULSE;
                PULSE:   if (cnt_reg == CNT_W'(EN_HIGH_CYCLES - 1)) state_next = SETTLE;
                SETTLE:  if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) state_next = MEASURE;
                MEASURE: if (sample_valid && cnt_reg == CNT_W'(WINDOW_LEN - 1)) state_next = COMPARE;
                COMPARE: state_next = (h_last && v_last) ? DONE : PULSE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg             <= '0;
            h_reg               <= '0;
            v_reg               <= '0;
            acc_reg             <= '0;
            best_acc_reg        <= '0;
            best_h_reg          <= '0;
            best_v_reg          <= '0;
            best_valid_reg      <= 1'b0;
            steering_angle_hori <= '0;
            steering_angle_vert <= '0;
            best_hori           <= '0;
            best_vert           <= '0;
            best_energy         <= '0;
        end else if (!abort) begin
            case (state_reg)
                IDLE: if (start) begin
                    h_reg               <= '0;
                    v_reg               <= '0;
                    cnt_reg             <= '0;
                    best_valid_reg      <= 1'b0;
                    best_acc_reg        <= '0;
                    best_h_reg          <= '0;
                    best_v_reg          <= '0;
                    steering_angle_hori <= '0;
                    steering_angle_vert <= '0;
                end
                PULSE: cnt_reg <= (cnt_reg == CNT_W'(EN_HIGH_CYCLES - 1)) ? '0 : cnt_reg + CNT_W'(1);
                SETTLE: begin
                    if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
                        cnt_reg <= '0;
                        acc_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                MEASURE: if (sample_valid) begin
                    acc_reg <= acc_reg + ACC_WIDTH'(sample_sq);
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
                COMPARE: begin
                    cnt_reg <= '0;
                    if (better) begin
                        best_acc_reg   <= acc_reg;
                        best_h_reg     <= steering_angle_hori;
                        best_v_reg     <= steering_angle_vert;
                        best_valid_reg <= 1'b1;
                    end
                    if (h_last && v_last) begin
                        // Results are published together with the done pulse; angles stay on the last point.
                        best_energy <= better ? acc_reg : best_acc_reg;
                        best_hori   <= better ? steering_angle_hori : best_h_reg;
                        best_vert   <= better ? steering_angle_vert : best_v_reg;
                    end else begin
                        h_reg               <= h_adv;
                        v_reg               <= v_adv;
                        steering_angle_hori <= to_angle(h_adv);
                        steering_angle_vert <= to_angle(v_adv);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef STEER_POINT_STREAM_EN
    assign point_valid  = (state_reg == COMPARE);
    assign point_hori   = point_valid ? steering_angle_hori : '0;
    assign point_vert   = point_valid ? steering_angle_vert : '0;
    assign point_energy = point_valid ? acc_reg : '0;
`endif

endmodule

// File: tb/tb_steering_scan_ctrl.sv
// Self-checking bench for steering_scan_ctrl: scenario table of full scans, abort/reset sequences,
// and a per-point energy model computed directly from the stimulus.
`timescale 1ns/1ps
module tb_steering_scan_ctrl;
    localparam int BW = 8, HS = 5, VS = 5, STRIDE = 1, ENH = 4, SETTLE = 64, WL = 256;
    localparam int AW = 2*BW + $clog2(WL);
    localparam int NP = HS*VS;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, sample_valid = 1'b0;
    logic [BW-1:0] data = '0;
    logic en, busy, done;
    logic [7:0] ang_h, ang_v, best_h, best_v;
    logic [AW-1:0] best_e;
`ifdef STEER_POINT_STREAM_EN
    logic pv;
    logic [7:0] ph, pvv;
    logic [AW-1:0] pe;
`endif

    steering_scan_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .sample_valid(sample_valid), .delay_sum_data_in(data),
        .steering_angle_en_async(en), .steering_angle_hori(ang_h), .steering_angle_vert(ang_v),
        .busy(busy), .done(done), .best_hori(best_h), .best_vert(best_v), .best_energy(best_e)
`ifdef STEER_POINT_STREAM_EN
        , .point_valid(pv), .point_hori(ph), .point_vert(pvv), .point_energy(pe)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int done_cnt = 0, pv_cnt = 0;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
`ifdef STEER_POINT_STREAM_EN
        if (pv === 1'b1) pv_cnt++;
`endif
    end

    typedef struct {
        int     mode;   // 0: +-10 at (2,3) only, 1: constant -128, 2: random per point
        int     gap;    // idle clocks before each valid sample, -1 = random 0..1
        int     exp_h;
        int     exp_v;
        longint exp_e;
    } scen_t;
    scen_t tbl[3];

    logic signed [7:0] rnd [NP][WL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic timeout_fail(input string what);
        checks++;
        failures++;
        $display("FAIL timeout_%s: got no event expected event within bound", what);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic int samp(input int mode, input int p, input int k);
        if (mode == 0) return (p == 3*HS + 2) ? ((k % 2 == 0) ? 10 : -10) : 0;
        if (mode == 1) return -128;
        return int'(rnd[p][k]);
    endfunction

    function automatic longint model_energy(input int mode, input int p);
        longint e = 0;
        for (int k = 0; k < WL; k++) e += longint'(samp(mode, p, k)) * longint'(samp(mode, p, k));
        return e;
    endfunction

    // One grid point: check enable width and angles, feed junk during settle (must be ignored),
    // then WL samples. stop_after>=0 leaves the DUT mid-MEASURE. start_at pulses start mid-window.
    task automatic do_point(input int mode, input int p, input int gap, input int stop_after, input int start_at);
        int cnt, n, g;
        int h = p % HS;
        int v = p / HS;
        cnt = 0;
        while (en !== 1'b1) begin
            tick;
            cnt++;
            if (cnt > 200) timeout_fail("enable_rise");
        end
        chk("angle_h_at_pulse", 64'(ang_h), 64'((h*STRIDE) & 255));
        chk("angle_v_at_pulse", 64'(ang_v), 64'((v*STRIDE) & 255));
        cnt = 0;
        while (en === 1'b1) begin
            cnt++;
            tick;
            if (cnt > 200) timeout_fail("enable_fall");
        end
        chk("enable_high_cycles", 64'(cnt), 64'(ENH));
        for (int i = 0; i < SETTLE; i++) begin
            sample_valid = 1'b1;
            data = BW'(100 + i);
            tick;
        end
        n = (stop_after >= 0) ? stop_after : WL;
        for (int k = 0; k < n; k++) begin
            g = (gap < 0) ? int'($urandom_range(0, 1)) : gap;
            for (int j = 0; j < g; j++) begin
                sample_valid = 1'b0;
                tick;
            end
            sample_valid = 1'b1;
            data = BW'(samp(mode, p, k));
            start = (k == start_at);
            tick;
            start = 1'b0;
        end
        sample_valid = 1'b0;
        if (stop_after >= 0) return;
        chk("busy_at_compare", 64'(busy), 64'(1));
        chk("done_at_compare", 64'(done), 64'(0));
        chk("angle_h_at_compare", 64'(ang_h), 64'((h*STRIDE) & 255));
        chk("angle_v_at_compare", 64'(ang_v), 64'((v*STRIDE) & 255));
`ifdef STEER_POINT_STREAM_EN
        chk("point_valid", 64'(pv), 64'(1));
        chk("point_hori", 64'(ph), 64'((h*STRIDE) & 255));
        chk("point_vert", 64'(pvv), 64'((v*STRIDE) & 255));
        chk("point_energy", 64'(pe), 64'(model_energy(mode, p)));
`endif
    endtask

    initial begin
        int d0, p0, bh;
        longint be, e;

        for (int p = 0; p < NP; p++) begin
            int amp = int'($urandom_range(1, 127));
            for (int k = 0; k < WL; k++) rnd[p][k] = 8'(int'($urandom_range(0, 2*amp)) - amp);
        end
        tbl[0] = '{mode: 0, gap: 3,  exp_h: 2, exp_v: 3, exp_e: 25600};
        tbl[1] = '{mode: 1, gap: 0,  exp_h: 0, exp_v: 0, exp_e: 4194304};
        bh = 0;
        be = model_energy(2, 0);
        for (int p = 1; p < NP; p++) begin
            e = model_energy(2, p);
            if (e > be) begin be = e; bh = p; end
        end
        tbl[2] = '{mode: 2, gap: -1, exp_h: ((bh % HS)*STRIDE) & 255, exp_v: ((bh / HS)*STRIDE) & 255, exp_e: be};

        // Reset state
        tick; tick;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_en", 64'(en), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_best_e", 64'(best_e), 64'(0));
        rst_n = 1'b1;
        tick;

        for (int s = 0; s < 3; s++) begin
            d0 = done_cnt;
            p0 = pv_cnt;
            start = 1'b1;
            tick;
            start = 1'b0;
            for (int p = 0; p < NP; p++) do_point(tbl[s].mode, p, tbl[s].gap, -1, -1);
            tick;
            chk("done_pulse", 64'(done), 64'(1));
            chk("busy_in_done", 64'(busy), 64'(1));
            chk("best_hori", 64'(best_h), 64'(tbl[s].exp_h));
            chk("best_vert", 64'(best_v), 64'(tbl[s].exp_v));
            chk("best_energy", 64'(best_e), 64'(tbl[s].exp_e));
            tick;
            chk("done_cleared", 64'(done), 64'(0));
            chk("busy_idle", 64'(busy), 64'(0));
            chk("done_count", 64'(done_cnt - d0), 64'(1));
`ifdef STEER_POINT_STREAM_EN
            chk("point_valid_count", 64'(pv_cnt - p0), 64'(NP));
`endif
            $display("scan %0d mode=%0d best=(%0d,%0d) energy=%0d", s, tbl[s].mode, best_h, best_v, best_e);
        end

        // Abort mid-MEASURE of point 7, with a start pulse while busy during point 3
        d0 = done_cnt;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int p = 0; p < 7; p++) do_point(1, p, 0, -1, (p == 3) ? 10 : -1);
        do_point(1, 7, 0, 100, -1);
        abort = 1'b1;
        tick;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_en", 64'(en), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_best_hori", 64'(best_h), 64'(tbl[2].exp_h));
        chk("abort_best_vert", 64'(best_v), 64'(tbl[2].exp_v));
        chk("abort_best_energy", 64'(best_e), 64'(tbl[2].exp_e));
        chk("abort_angle_h_hold", 64'(ang_h), 64'((2*STRIDE) & 255));
        chk("abort_angle_v_hold", 64'(ang_v), 64'((1*STRIDE) & 255));
        abort = 1'b0;
        for (int i = 0; i < 30; i++) begin
            sample_valid = 1'(($urandom_range(0, 1)));
            tick;
        end
        sample_valid = 1'b0;
        chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
        chk("abort_stays_idle", 64'(busy), 64'(0));
        $display("abort sequence: busy=%0d done_count_delta=%0d", busy, done_cnt - d0);

        // Start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'(0));
        chk("start_abort_en", 64'(en), 64'(0));
        tick;
        chk("start_abort_idle", 64'(busy), 64'(0));

        // Asynchronous reset mid-MEASURE of point 3
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int p = 0; p < 3; p++) do_point(1, p, 0, -1, -1);
        do_point(1, 3, 0, 50, -1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_en", 64'(en), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_angle_h", 64'(ang_h), 64'(0));
        chk("arst_angle_v", 64'(ang_v), 64'(0));
        chk("arst_best_hori", 64'(best_h), 64'(0));
        chk("arst_best_vert", 64'(best_v), 64'(0));
        chk("arst_best_energy", 64'(best_e), 64'(0));
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        chk("post_rst_idle", 64'(busy), 64'(0));
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("post_rst_start_en", 64'(en), 64'(1));
        chk("post_rst_start_busy", 64'(busy), 64'(1));
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("post_rst_abort_idle", 64'(busy), 64'(0));
        $display("reset sequence: busy=%0d en=%0d", busy, en);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/steering_scan_ctrl.md
Name: steering_scan_ctrl

Overview:
- Initiator side of the beamformer steering interface.
- Steps the beamformer through a grid of horizontal/vertical steering angles and pulses the steering enable at each grid point.
- After a settle time, integrates the energy of the delay-and-sum output stream at each point.
- Reports the angle pair with the highest energy, giving a steered-response-power source locator for the mic array.

Parameters:
- BIT_WIDTH, 8: width of the beamformer output sample, interpreted as two's complement.
- HORI_STEPS, 5: number of horizontal grid points (inner loop).
- VERT_STEPS, 5: number of vertical grid points (outer loop).
- ANGLE_STRIDE, 1: angle increment per grid step; angle = index*ANGLE_STRIDE, truncated to 8 bits.
- EN_HIGH_CYCLES, 4: clocks the steering enable is held high per point; minimum 2.
- SETTLE_CYCLES, 64: clocks waited after the enable falls, covering delay recompute and delay-line refill.
- WINDOW_LEN, 256: valid samples integrated per point; must be a power of 2.
- ACC_WIDTH, 2*BIT_WIDTH+$clog2(WINDOW_LEN): energy accumulator width.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  1-cycle pulse; begins a scan when idle
- abort  input  1  level; terminates a scan in progress
- sample_valid  input  1  new beamformer output sample this cycle
- delay_sum_data_in  input  BIT_WIDTH  beamformer output sample
- steering_angle_en_async  output  1  steering enable to beamformer
- steering_angle_hori  output  8  horizontal steering angle
- steering_angle_vert  output  8  vertical steering angle
- busy  output  1  scan in progress
- done  output  1  1-cycle pulse on scan completion
- best_hori  output  8  winning horizontal angle
- best_vert  output  8  winning vertical angle
- best_energy  output  ACC_WIDTH  winning energy

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset value of every output and internal register is 0.
- States: IDLE, PULSE, SETTLE, MEASURE, COMPARE, DONE.
- IDLE: busy=0. On start, go to PULSE:
  - point indices h=v=0;
  - internal best registers cleared, best-valid flag cleared.
- PULSE:
  - Angle outputs are driven to h*ANGLE_STRIDE and v*ANGLE_STRIDE on PULSE entry.
  - Angle outputs are held constant until the next PULSE entry.
  - Enable is high for exactly EN_HIGH_CYCLES clocks, then go to SETTLE.
- SETTLE:
  - Enable low.
  - Counts SETTLE_CYCLES clocks, ignoring sample_valid.
  - Clears the accumulator and sample counter on its last cycle, then goes to MEASURE.
- MEASURE:
  - On each sample_valid, the accumulator adds sample*sample (signed square, 2*BIT_WIDTH bits, zero-extended).
  - Counter increments on each sample_valid.
  - After the WINDOW_LEN-th valid sample, go to COMPARE.
  - sample_valid gaps only stall the count; no timeout.
- COMPARE (1 cycle):
  - If no best is held yet, or acc > best (strictly greater), latch acc, h, and v as best.
  - Ties keep the earlier point.
  - Advance order: h increments; when h==HORI_STEPS-1, h wraps to 0 and v increments.
  - Last point is (HORI_STEPS-1, VERT_STEPS-1). Go to DONE after the last point, else go to PULSE.
- DONE (1 cycle):
  - best_hori/best_vert/best_energy outputs register the best values.
  - done=1, busy=1, then go to IDLE.
  - Result outputs change only in DONE.
- busy=1 in every state except IDLE.
- start while busy is ignored.
- abort has priority over all transitions:
  - from any non-IDLE state, go to IDLE on the next edge;
  - enable forced 0 that edge;
  - no done pulse;
  - result outputs retain the previous scan's values;
  - angle outputs hold their last value.
- Simultaneous start and abort in IDLE: abort wins, no scan starts.
- Accumulator is sized so it cannot overflow: worst case (-2^(BIT_WIDTH-1))^2*WINDOW_LEN fits in ACC_WIDTH bits.
- Per-point latency: EN_HIGH_CYCLES + SETTLE_CYCLES + (cycles to collect WINDOW_LEN valids) + 1.
- Scan latency: start to done = 1 + HORI_STEPS*VERT_STEPS*(per-point latency) + ... final DONE cycle.

Optional Feature:
- Macro: STEER_POINT_STREAM_EN.
- When defined, adds these outputs:
  - point_valid (1)
  - point_hori (8)
  - point_vert (8)
  - point_energy (ACC_WIDTH)
- In every COMPARE cycle, point_valid=1 for one cycle, carrying that point's angles and accumulated energy, for host-side power-map capture.
- All four outputs reset to 0.
- When not defined, these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset with rst_n low mid-MEASURE -> all outputs immediately 0, busy=0, enable=0; after release, state is IDLE.
- Default params; sample_valid every 4th clock; data 0 everywhere except ±10 alternating at grid point h=2, v=3 -> exactly one done; best_hori=2, best_vert=3, best_energy=25600.
- Enable waveform over one scan -> 25 enable pulses, each exactly 4 clocks high; angles stable from each PULSE entry through its COMPARE; angle sequence (0,0),(1,0)..(4,0),(0,1)..(4,4).
- All points fed constant -128 -> best_hori=0, best_vert=0 (tie keeps first), best_energy=4194304 with no wrap.
- Abort asserted during point 7 MEASURE -> busy=0 the next cycle, no done, best_* unchanged from the prior scan; start pulsed while busy is ignored, with no restart and no second done.
- With STEER_POINT_STREAM_EN, the test 2 stimulus -> 25 point_valid pulses; point (2,3) carries energy 25600, all others carry 0.
